// File: rtl/dac_iq_ramp_interface.sv
// dac_iq_ramp_interface
// Buffers I/Q pairs from the PSK modulator in a small FIFO and serialises them
// onto one offset-binary DAC bus (I then Q on alternate clocks). A linear gain
// ramp is applied at the start and end of each burst. The bus rests at
// mid-scale while idle. Underflow events are counted and overflow is sticky.
module dac_iq_ramp_interface #(
  parameter int DW          = 12,
  parameter int FIFO_DEPTH  = 8,
  parameter int RAMP_SHIFT  = 4,
  parameter int START_LEVEL = 4
) (
  input  logic          clk_32M768,
  input  logic          rst_n_32M768,
  input  logic          tx_en,
  input  logic [DW-1:0] s_i,
  input  logic [DW-1:0] s_q,
  input  logic          s_valid,
  output logic [DW-1:0] dac_data,
  output logic          dac_iq_sel,
  output logic          dac_active,
  output logic [7:0]    underflow_cnt,
  output logic          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = RAMP_SHIFT + 1;
  localparam int PW = DW + RAMP_SHIFT + 1;

  localparam logic [GW-1:0] GAIN_FULL = {1'b1, {RAMP_SHIFT{1'b0}}};
  localparam logic [GW-1:0] GAIN_ONE  = GW'(1);
  localparam logic [LW-1:0] FULL_LV   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] START_LV  = LW'(START_LEVEL);
  localparam logic [DW-1:0] MID_SCALE = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    ACTIVE    = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t          state_reg, state_next;
  logic [GW-1:0]   gain_reg, gain_next;
  logic            phase_reg;
  logic            boundary;

  logic [2*DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic            fifo_full, fifo_empty;
  logic            flush, push, pop;
  logic [2*DW-1:0] fifo_head;

  logic [DW-1:0]   hold_i_reg, hold_q_reg;
  logic [DW-1:0]   hold_i_next, hold_q_next;

  logic            uf_inc;
  logic [DW-1:0]   dac_data_reg, dac_data_next;
  logic            dac_iq_sel_reg;
  logic            dac_active_reg;
  logic [7:0]      underflow_cnt_reg;
  logic            overflow_reg;

  // Signed multiply by the ramp gain followed by a floor shift; the result is
  // converted to offset binary by flipping the sign bit.
  function automatic logic [DW-1:0] scale(input logic [DW-1:0] x,
                                          input logic [GW-1:0] g);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ge;
    logic signed [PW-1:0] prod;
    logic [DW-1:0]        res;
    xe   = $signed({{(RAMP_SHIFT+1){x[DW-1]}}, x});
    ge   = $signed({{DW{1'b0}}, g});
    prod = xe * ge;
    res  = DW'(prod >>> RAMP_SHIFT);
    res[DW-1] = ~res[DW-1];
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Pair timing: phase 0 marks a pair boundary, where pops and state changes
  // happen; phase 1 is the Q half of the pair.
  // ---------------------------------------------------------------------------
  assign boundary = ~phase_reg;

  // Phase toggles every clock starting from a pair boundary after reset
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      phase_reg <= 1'b0;
    end else begin
      phase_reg <= ~phase_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  assign fifo_full  = (level_reg == FULL_LV);
  assign fifo_empty = (level_reg == '0);
  assign flush      = (state_reg == IDLE) && !tx_en;
  assign push       = s_valid && !fifo_full && !flush;
  assign fifo_head  = mem[rd_ptr_reg];

  // Pair storage; no reset needed since the pointers define valid contents
  always_ff @(posedge clk_32M768) begin
    if (push) begin
      mem[wr_ptr_reg] <= {s_i, s_q};
    end
  end

  // FIFO pointers and fill level; a flush discards everything queued
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      level_reg <= level_reg + LW'(push) - LW'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Burst state machine
  // ---------------------------------------------------------------------------

  // State and gain registers
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      state_reg <= IDLE;
      gain_reg  <= '0;
    end else begin
      state_reg <= state_next;
      gain_reg  <= gain_next;
    end
  end

  // Next state, gain step and pop decision, evaluated only at pair boundaries
  always_comb begin
    state_next = state_reg;
    gain_next  = gain_reg;
    pop        = 1'b0;
    uf_inc     = 1'b0;
    if (boundary) begin
      case (state_reg)
        IDLE: begin
          gain_next = '0;
          if (tx_en && (level_reg >= START_LV)) begin
            pop        = 1'b1;
            gain_next  = GAIN_ONE;
            state_next = (GAIN_ONE == GAIN_FULL) ? ACTIVE : RAMP_UP;
          end
        end
        RAMP_UP, ACTIVE: begin
          if (fifo_empty || !tx_en) begin
            // An empty FIFO counts as an underflow even if tx_en also dropped
            uf_inc     = fifo_empty;
            gain_next  = gain_reg - GAIN_ONE;
            state_next = (gain_next == '0) ? IDLE : RAMP_DOWN;
          end else begin
            pop = 1'b1;
            if (state_reg == RAMP_UP) begin
              gain_next = gain_reg + GAIN_ONE;
              if (gain_next == GAIN_FULL) begin
                state_next = ACTIVE;
              end
            end
          end
        end
        RAMP_DOWN: begin
          // Ramp always runs to completion; new data or tx_en cannot reverse it
          if (gain_reg == '0) begin
            state_next = IDLE;
          end else begin
            gain_next  = gain_reg - GAIN_ONE;
            state_next = (gain_next == '0) ? IDLE : RAMP_DOWN;
          end
        end
        default: begin
          state_next = IDLE;
          gain_next  = '0;
        end
      endcase
    end
  end

  // Output word selection: I of the (possibly new) pair at a boundary, Q of
  // the held pair otherwise, mid-scale whenever the relevant state is IDLE
  always_comb begin
    hold_i_next = hold_i_reg;
    hold_q_next = hold_q_reg;
    if (pop) begin
      hold_i_next = fifo_head[2*DW-1:DW];
      hold_q_next = fifo_head[DW-1:0];
    end
    if (boundary) begin
      dac_data_next = (state_next == IDLE) ? MID_SCALE : scale(hold_i_next, gain_next);
    end else begin
      dac_data_next = (state_reg == IDLE) ? MID_SCALE : scale(hold_q_reg, gain_reg);
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and status
  // ---------------------------------------------------------------------------

  // Hold register and DAC bus; the popped pair reaches the bus one clock later
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      hold_i_reg     <= '0;
      hold_q_reg     <= '0;
      dac_data_reg   <= MID_SCALE;
      dac_iq_sel_reg <= 1'b0;
      dac_active_reg <= 1'b0;
    end else begin
      hold_i_reg     <= hold_i_next;
      hold_q_reg     <= hold_q_next;
      dac_data_reg   <= dac_data_next;
      dac_iq_sel_reg <= phase_reg;
      dac_active_reg <= (state_next != IDLE);
    end
  end

  // Saturating underflow counter and sticky overflow flag
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      underflow_cnt_reg <= '0;
      overflow_reg      <= 1'b0;
    end else begin
      if (uf_inc && (underflow_cnt_reg != 8'hFF)) begin
        underflow_cnt_reg <= underflow_cnt_reg + 8'd1;
      end
      if (s_valid && fifo_full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign dac_data      = dac_data_reg;
  assign dac_iq_sel    = dac_iq_sel_reg;
  assign dac_active    = dac_active_reg;
  assign underflow_cnt = underflow_cnt_reg;
  assign overflow      = overflow_reg;

endmodule

// File: tb/tb_dac_iq_ramp_interface.sv
// tb_dac_iq_ramp_interface
// Directed bench: a vector table covers the idle fill and the first ramp steps,
// then a scripted cycle sequence covers ramp-up, drain/underflow, flush,
// tx_en ramp-down with overflow, and an asynchronous reset mid-ramp.
module tb_dac_iq_ramp_interface;

  logic        clk_32M768;
  logic        rst_n_32M768;
  logic        tx_en;
  logic [11:0] s_i;
  logic [11:0] s_q;
  logic        s_valid;
  logic [11:0] dac_data;
  logic        dac_iq_sel;
  logic        dac_active;
  logic [7:0]  underflow_cnt;
  logic        overflow;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  dac_iq_ramp_interface #(
    .DW(12), .FIFO_DEPTH(8), .RAMP_SHIFT(4), .START_LEVEL(4)
  ) dut (
    .clk_32M768   (clk_32M768),
    .rst_n_32M768 (rst_n_32M768),
    .tx_en        (tx_en),
    .s_i          (s_i),
    .s_q          (s_q),
    .s_valid      (s_valid),
    .dac_data     (dac_data),
    .dac_iq_sel   (dac_iq_sel),
    .dac_active   (dac_active),
    .underflow_cnt(underflow_cnt),
    .overflow     (overflow)
  );

  initial clk_32M768 = 1'b0;
  always #5 clk_32M768 = ~clk_32M768;

  typedef struct {
    logic        tx_en;
    logic        s_valid;
    logic [11:0] s_i;
    logic [11:0] s_q;
    logic [11:0] exp_data;
    logic        exp_sel;
    logic        exp_active;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int at, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, at, act, exp);
    end
  endtask

  // Apply inputs, advance one rising edge, return on the following falling edge
  task automatic tick(input logic tx, input logic sv, input logic [11:0] si,
                      input logic [11:0] sq);
    tx_en   = tx;
    s_valid = sv;
    s_i     = si;
    s_q     = sq;
    @(posedge clk_32M768);
    cyc++;
    @(negedge clk_32M768);
  endtask

  // Hand-derived bus words. Normal pair I=0x7FF, Q=0x800:
  //   floor(2047*g/16) = 128g-1, and -2048*g/16 = -128g.
  // Marker pair I=0x100, Q=0xF00: +/-16g exactly.
  function automatic logic [11:0] norm_i(input int g); return 12'(2048 + 128*g - 1); endfunction
  function automatic logic [11:0] norm_q(input int g); return 12'(2048 - 128*g);     endfunction
  function automatic logic [11:0] mark_i(input int g); return 12'(2048 + 16*g);      endfunction
  function automatic logic [11:0] mark_q(input int g); return 12'(2048 - 16*g);      endfunction

  // Scripted stimulus and expectation per rising-edge number n (n = 13..192).
  // kind: 0 = idle (mid-scale), 1 = normal pair at gain g, 2 = marker pair at gain g.
  function automatic void scen(input int n, output logic tx, output logic sv,
                               output logic [11:0] si, output logic [11:0] sq,
                               output int kind, output int g);
    int b;
    b    = (n % 2 == 1) ? n : n - 1;
    tx   = 1'b1;
    sv   = 1'b0;
    si   = 12'h7FF;
    sq   = 12'h800;
    kind = 0;
    g    = 0;
    if (n <= 82) begin
      // Ramp-up, full scale, then strobes stop after the marker pair at edge 41
      sv = (n % 2 == 1) && (n <= 41);
      if (n == 41) begin
        si = 12'h100;
        sq = 12'hF00;
      end
      if (b <= 47) begin
        kind = 1;
        g    = ((b - 9) / 2 + 1 > 16) ? 16 : (b - 9) / 2 + 1;
      end else if (b == 49) begin
        kind = 2;
        g    = 16;
      end else if (b <= 79) begin
        kind = 2;
        g    = 15 - (b - 51) / 2;
      end
    end else if (n <= 102) begin
      // Ten strobes with tx_en low while idle: everything is flushed
      tx = 1'b0;
      sv = (n % 2 == 1);
    end else if (n <= 174) begin
      // Restart, reach full scale, drop tx_en with 4 queued, keep writing
      tx = (n <= 142);
      sv = (n % 2 == 1) && (n <= 151);
      if (b >= 111 && b <= 141) begin
        kind = 1;
        g    = (b - 111) / 2 + 1;
      end else if (b >= 143 && b <= 171) begin
        kind = 1;
        g    = 15 - (b - 143) / 2;
      end
    end else begin
      // After the flush: three pairs keep it idle, the fourth starts a ramp
      sv = (n % 2 == 1);
      if (b >= 183) begin
        kind = 1;
        g    = (b - 183) / 2 + 1;
      end
    end
  endfunction

  initial begin
    logic        tx, sv;
    logic [11:0] si, sq, exp_d;
    int          kind, g;

    // Fill + first ramp steps: strobes on odd edges, boundaries on odd edges
    vecs[0]  = '{1'b1, 1'b1, 12'h7FF, 12'h800, 12'h800, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 12'h7FF, 12'h800, 12'h800, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 12'h7FF, 12'h800, 12'h800, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 12'h7FF, 12'h800, 12'h800, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 12'h7FF, 12'h800, 12'h800, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 12'h7FF, 12'h800, 12'h800, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 12'h7FF, 12'h800, 12'h800, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 12'h7FF, 12'h800, 12'h800, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 12'h7FF, 12'h800, 12'h87F, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 12'h7FF, 12'h800, 12'h780, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 12'h7FF, 12'h800, 12'h8FF, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 12'h7FF, 12'h800, 12'h700, 1'b1, 1'b1};

    rst_n_32M768 = 1'b0;
    tx_en   = 1'b0;
    s_valid = 1'b0;
    s_i     = '0;
    s_q     = '0;
    repeat (3) @(negedge clk_32M768);
    chk("rst_data",   0, 32'(dac_data),      32'h800);
    chk("rst_sel",    0, 32'(dac_iq_sel),    32'h0);
    chk("rst_active", 0, 32'(dac_active),    32'h0);
    chk("rst_ucnt",   0, 32'(underflow_cnt), 32'h0);
    chk("rst_ovf",    0, 32'(overflow),      32'h0);
    rst_n_32M768 = 1'b1;
    cyc = 0;

    for (int k = 0; k < 12; k++) begin
      tick(vecs[k].tx_en, vecs[k].s_valid, vecs[k].s_i, vecs[k].s_q);
      $display("vec %0d cyc %0d: data=%03h sel=%0b active=%0b", k, cyc, dac_data,
               dac_iq_sel, dac_active);
      chk("tbl_data",   cyc, 32'(dac_data),   32'(vecs[k].exp_data));
      chk("tbl_sel",    cyc, 32'(dac_iq_sel), 32'(vecs[k].exp_sel));
      chk("tbl_active", cyc, 32'(dac_active), 32'(vecs[k].exp_active));
    end

    for (int n = 13; n <= 192; n++) begin
      scen(n, tx, sv, si, sq, kind, g);
      tick(tx, sv, si, sq);
      if (kind == 0)      exp_d = 12'h800;
      else if (kind == 1) exp_d = (n % 2 == 1) ? norm_i(g) : norm_q(g);
      else                exp_d = (n % 2 == 1) ? mark_i(g) : mark_q(g);
      $display("cyc %0d: data=%03h sel=%0b active=%0b ucnt=%0d ovf=%0b", cyc, dac_data,
               dac_iq_sel, dac_active, underflow_cnt, overflow);
      chk("seq_data",   cyc, 32'(dac_data),   32'(exp_d));
      chk("seq_sel",    cyc, 32'(dac_iq_sel), 32'(n % 2 == 0));
      chk("seq_active", cyc, 32'(dac_active), 32'(kind != 0));
      if (n == 50)  chk("ucnt_before_drain", cyc, 32'(underflow_cnt), 32'd0);
      if (n == 51)  chk("ucnt_after_drain",  cyc, 32'(underflow_cnt), 32'd1);
      if (n == 102) chk("ovf_after_flush",   cyc, 32'(overflow),      32'd0);
      if (n == 149) chk("ovf_at_full",       cyc, 32'(overflow),      32'd0);
      if (n == 151) chk("ovf_set",           cyc, 32'(overflow),      32'd1);
      if (n == 173) chk("ovf_sticky",        cyc, 32'(overflow),      32'd1);
      if (n == 173) chk("ucnt_txen_drop",    cyc, 32'(underflow_cnt), 32'd1);
    end

    // Asynchronous reset in the middle of the clock, during ramp-up at gain 5
    #2 rst_n_32M768 = 1'b0;
    #1;
    $display("async reset: data=%03h sel=%0b active=%0b ucnt=%0d ovf=%0b", dac_data,
             dac_iq_sel, dac_active, underflow_cnt, overflow);
    chk("arst_data",   cyc, 32'(dac_data),      32'h800);
    chk("arst_sel",    cyc, 32'(dac_iq_sel),    32'h0);
    chk("arst_active", cyc, 32'(dac_active),    32'h0);
    chk("arst_ucnt",   cyc, 32'(underflow_cnt), 32'h0);
    chk("arst_ovf",    cyc, 32'(overflow),      32'h0);
    repeat (2) @(negedge clk_32M768);
    rst_n_32M768 = 1'b1;

    // FIFO and state must be cleared: no burst starts without new data
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, 1'b0, 12'h7FF, 12'h800);
      $display("post-reset %0d: data=%03h sel=%0b active=%0b", k, dac_data, dac_iq_sel,
               dac_active);
      chk("prst_data",   k, 32'(dac_data),   32'h800);
      chk("prst_sel",    k, 32'(dac_iq_sel), 32'(k % 2 == 0));
      chk("prst_active", k, 32'(dac_active), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
